// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package riscv_fetch_pkg;

    localparam int unsigned INSTR_BYTES  = 4;
    localparam int unsigned FETCH_QDEPTH = 2;
    localparam int unsigned QCOUNT_W     = $clog2(FETCH_QDEPTH + 1);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StDrain,
        StHalt
    } fetch_state_e;

    // One queued instruction together with the address it was fetched from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched instructions feeding decode.
module fetch_queue
    import riscv_fetch_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                push,
    input  fetch_entry_t        push_entry,
    input  logic                pop,
    input  logic                flush,
    output logic [QCOUNT_W-1:0] count,
    output fetch_entry_t        head
);

    localparam logic [QCOUNT_W-1:0] QFULL = QCOUNT_W'(FETCH_QDEPTH);

    fetch_entry_t entries [FETCH_QDEPTH];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         do_push;
    logic         do_pop;

    // Guard against popping empty or pushing full; the issue rule keeps the latter unreachable.
    always_comb begin
        do_pop  = pop && (count != '0);
        do_push = push && ((count != QFULL) || do_pop);
    end

    // Storage, pointers and occupancy; flush discards contents but leaves storage untouched.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            entries[0] <= '0;
            entries[1] <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= '0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (do_push) begin
                entries[wr_ptr] <= push_entry;
                wr_ptr          <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign head = entries[rd_ptr];

endmodule

// File: rtl/pc_fetch_unit.sv
// PC owner and single-outstanding fetch sequencer with redirect/flush handling.
module pc_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready,
    output logic        fetch_fault
);

    localparam logic [QCOUNT_W-1:0] QFULL = QCOUNT_W'(FETCH_QDEPTH);

    fetch_state_e          state_q, state_d;
    logic [31:0]           pc_q, pc_d;
    logic [31:0]           req_pc_q, req_pc_d;
    logic                  fault_q, fault_d;
    logic                  q_push, q_pop, q_flush;
    logic [QCOUNT_W-1:0]   q_count;
    logic [QCOUNT_W-1:0]   count_after;
    fetch_entry_t          q_head;
    fetch_entry_t          q_entry;
    logic                  accept;

    assign accept  = (state_q == StReq) && imem_req_ready;
    assign q_pop   = if_valid && if_ready;
    assign q_entry = '{pc: req_pc_q, instr: imem_resp_data};

    fetch_queue u_queue (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (q_push),
        .push_entry (q_entry),
        .pop        (q_pop),
        .flush      (q_flush),
        .count      (q_count),
        .head       (q_head)
    );

    // Next-state, PC advance, queue push/flush and fault capture.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        fault_d     = fault_q;
        q_push      = 1'b0;
        q_flush     = 1'b0;
        count_after = q_pop ? q_count : q_count + 1'b1;

        unique case (state_q)
            StIdle: begin
                if (q_count < QFULL) state_d = StReq;
            end
            StReq: begin
                if (imem_req_ready) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + 32'(INSTR_BYTES);
                    state_d  = StWait;
                end
            end
            StWait: begin
                if (imem_resp_valid) begin
                    q_push  = 1'b1;
                    state_d = (count_after < QFULL) ? StReq : StIdle;
                end
            end
            StDrain: begin
                if (imem_resp_valid) state_d = StReq;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: state_d = StIdle;
        endcase

        // Redirect overrides everything; a response arriving with it is stale and dropped.
        if (redirect_valid && (state_q != StHalt)) begin
            q_push  = 1'b0;
            q_flush = 1'b1;
            pc_d    = redirect_pc;
            if (redirect_pc[1:0] != 2'b00) begin
                fault_d = 1'b1;
                state_d = StHalt;
            end else if (accept ||
                         (((state_q == StWait) || (state_q == StDrain)) && !imem_resp_valid)) begin
                state_d = StDrain;
            end else begin
                state_d = StReq;
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            fault_q  <= fault_d;
        end
    end

    assign imem_req_valid = (state_q == StReq);
    assign imem_req_addr  = pc_q;
    assign if_valid       = (q_count != '0) && (state_q != StHalt);
    assign if_instr       = q_head.instr;
    assign if_pc          = q_head.pc;
    assign fetch_fault    = fault_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: fixed vectors, directed corner cases, random traffic.
module tb_pc_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        fetch_fault;

    pc_fetch_unit #(.RESET_PC(RPC)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_ready        (if_ready),
        .fetch_fault     (fetch_fault)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    // Memory model: one request in flight, answered after a latency in cycles.
    logic        pend;
    logic [31:0] pend_addr;
    int          cnt;
    int          lat;
    logic        rand_mode;
    // Reference stream: next expected decoded pc and next expected request address.
    logic [31:0] exp_pc;
    logic [31:0] exp_req;
    logic        hold_prev;
    logic [31:0] hold_addr;
    logic        saw_zero;
    int          n_acc;
    int          n_pop;

    typedef struct {
        logic        rv;
        logic [31:0] rdata;
        logic        exp_req_v;
        logic [31:0] exp_addr;
        logic        exp_if_v;
        logic [31:0] exp_if_pc;
    } vec_t;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Enter at a negedge; leave at a negedge with reset_n released and the model cleared.
    task automatic do_reset(input int n);
        reset_n         = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        if_ready        = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_req_addr", imem_req_addr, RPC);
        chk("rst_if_valid", if_valid, 0);
        chk("rst_if_instr", if_instr, 0);
        chk("rst_if_pc", if_pc, 0);
        chk("rst_fault", fetch_fault, 0);
        reset_n   = 1'b1;
        pend      = 1'b0;
        pend_addr = '0;
        cnt       = 0;
        exp_pc    = RPC;
        exp_req   = RPC;
        hold_prev = 1'b0;
        hold_addr = '0;
        saw_zero  = 1'b0;
        n_acc     = 0;
        n_pop     = 0;
    endtask

    // One cycle: drive memory, check outputs against the reference stream, advance the model.
    task automatic tick();
        logic        acc;
        logic        pop;
        logic [31:0] a;
        if (pend && cnt == 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = memword(pend_addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
        imem_req_ready = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (hold_prev) chk("req_hold", {imem_req_valid, imem_req_addr}, {1'b1, hold_addr});
        if (imem_req_valid) chk("one_outstanding", pend, 0);
        acc = imem_req_valid & imem_req_ready;
        a   = imem_req_addr;
        if (acc) begin
            chk("req_addr", a, exp_req);
            if (a == 32'h0) saw_zero = 1'b1;
        end
        pop = if_valid & if_ready & ~redirect_valid;
        if (pop) begin
            chk("if_pc", if_pc, exp_pc);
            chk("if_instr", if_instr, memword(exp_pc));
        end
        hold_prev = imem_req_valid & ~imem_req_ready & ~redirect_valid;
        hold_addr = a;
        @(posedge clk);
        if (pend) begin
            if (cnt == 0) pend = 1'b0;
            else cnt--;
        end
        if (acc) begin
            pend      = 1'b1;
            pend_addr = a;
            cnt       = (rand_mode ? int'($urandom_range(1, 3)) : lat) - 1;
            exp_req   = exp_req + 32'd4;
            n_acc++;
        end
        if (pop) begin
            exp_pc = exp_pc + 32'd4;
            n_pop++;
        end
        if (redirect_valid) begin
            exp_pc  = redirect_pc;
            exp_req = redirect_pc;
        end
        @(negedge clk);
    endtask

    initial begin
        vec_t vecs [8];
        rand_mode = 1'b0;
        lat       = 1;

        // Zero-wait memory, decode always ready: one instruction every two cycles.
        vecs[0] = '{1'b0, 32'h0, 1'b0, 32'h100, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 32'h0};
        vecs[2] = '{1'b1, memword(32'h100), 1'b0, 32'h104, 1'b0, 32'h0};
        vecs[3] = '{1'b0, 32'h0, 1'b1, 32'h104, 1'b1, 32'h100};
        vecs[4] = '{1'b1, memword(32'h104), 1'b0, 32'h108, 1'b0, 32'h0};
        vecs[5] = '{1'b0, 32'h0, 1'b1, 32'h108, 1'b1, 32'h104};
        vecs[6] = '{1'b1, memword(32'h108), 1'b0, 32'h10C, 1'b0, 32'h0};
        vecs[7] = '{1'b0, 32'h0, 1'b1, 32'h10C, 1'b1, 32'h108};

        reset_n = 1'b0;
        @(negedge clk);
        do_reset(2);
        for (int i = 0; i < 8; i++) begin
            imem_req_ready  = 1'b1;
            if_ready        = 1'b1;
            imem_resp_valid = vecs[i].rv;
            imem_resp_data  = vecs[i].rdata;
            chk("vec_req_valid", imem_req_valid, vecs[i].exp_req_v);
            chk("vec_req_addr", imem_req_addr, vecs[i].exp_addr);
            chk("vec_if_valid", if_valid, vecs[i].exp_if_v);
            if (vecs[i].exp_if_v) begin
                chk("vec_if_pc", if_pc, vecs[i].exp_if_pc);
                chk("vec_if_instr", if_instr, memword(vecs[i].exp_if_pc));
            end
            @(posedge clk);
            @(negedge clk);
        end

        // Decode stalled: queue fills to two, then requests stop; release keeps order.
        do_reset(2);
        if_ready = 1'b0;
        repeat (10) tick();
        chk("stall_accepts", n_acc, 2);
        chk("stall_if_valid", if_valid, 1);
        chk("stall_if_pc", if_pc, RPC);
        chk("stall_no_req", imem_req_valid, 0);
        if_ready = 1'b1;
        repeat (12) tick();
        chk("stall_release_pops", n_pop >= 4, 1);

        // Redirect while waiting on a 3-cycle memory: stale response drained.
        do_reset(2);
        lat = 3;
        for (int i = 0; i < 10 && n_acc < 1; i++) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2000;
        tick();
        redirect_valid = 1'b0;
        chk("drain1_no_req", imem_req_valid, 0);
        chk("drain1_if_valid", if_valid, 0);
        tick();
        chk("drain2_no_req", imem_req_valid, 0);
        chk("drain2_if_valid", if_valid, 0);
        tick();
        chk("drain_restart", {imem_req_valid, imem_req_addr}, {1'b1, 32'h0000_2000});
        for (int i = 0; i < 30 && n_pop < 1; i++) tick();
        chk("drain_pop_seen", n_pop >= 1, 1);

        // Redirect together with a response and a decode pop.
        do_reset(2);
        lat      = 1;
        if_ready = 1'b0;
        for (int i = 0; i < 20 && n_acc < 2; i++) tick();
        chk("coll_pre_if_valid", if_valid, 1);
        chk("coll_pre_resp_due", pend && cnt == 0, 1);
        if_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3000;
        tick();
        redirect_valid = 1'b0;
        chk("coll_if_valid", if_valid, 0);
        chk("coll_req", {imem_req_valid, imem_req_addr}, {1'b1, 32'h0000_3000});
        repeat (10) tick();
        chk("coll_pops", n_pop >= 1, 1);

        // Address wrap past 0xFFFF_FFFC.
        do_reset(2);
        repeat (2) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        repeat (16) tick();
        chk("wrap_saw_zero", saw_zero, 1);

        // Misaligned redirect: sticky fault, halt until reset.
        do_reset(2);
        repeat (6) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2002;
        tick();
        redirect_valid = 1'b0;
        chk("fault_set", fetch_fault, 1);
        for (int i = 0; i < 8; i++) begin
            chk("halt_state", {fetch_fault, imem_req_valid, if_valid}, {1'b1, 1'b0, 1'b0});
            tick();
        end
        do_reset(1);
        for (int i = 0; i < 10 && n_acc < 1; i++) tick();
        chk("fault_restart_req", n_acc, 1);

        // Random traffic against the reference stream.
        do_reset(2);
        rand_mode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if_ready       = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 39) == 0);
            redirect_pc    = $urandom & 32'hFFFF_FFFC;
            tick();
        end
        redirect_valid = 1'b0;
        chk("rand_progress", n_pop > 100, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
